// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out word serializer with valid/ready intake
//
// Ports:
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   din        : parallel word to transmit (WIDTH bits)
//   din_valid  : din holds a word offered for transmission
//   din_ready  : word on din is taken on this edge if din_valid is high
//   sout       : serial data bit (registered)
//   sout_valid : sout carries a data bit this cycle (registered)
//   sout_last  : sout carries the final bit of a word (registered)
//   busy       : a word is being shifted out (registered)
//
// Parameters:
//   WIDTH      : parallel word width, 2..32
//   MSB_FIRST  : 1 sends bit WIDTH-1 first, 0 sends bit 0 first

module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;

    logic             last_bit;
    logic             hs;
    logic             bit_now;
    logic             sout_nx;
    logic             sout_valid_nx;
    logic             sout_last_nx;

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign hs       = din_valid && din_ready;
    assign bit_now  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    // State register. The output registers trail the state by one cycle,
    // so a word loaded at edge N shows its first bit after edge N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            shreg      <= shreg_nx;
            sout       <= sout_nx;
            sout_valid <= sout_valid_nx;
            sout_last  <= sout_last_nx;
            busy       <= sout_valid_nx;
        end
    end

    // Next-state logic. A word accepted on the last-bit cycle reloads the
    // shifter directly so the next word follows with no gap cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    shreg_nx = din;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    cnt_nx = '0;
                    if (hs) begin
                        shreg_nx = din;
                    end else begin
                        state_nx = IDLE;
                        shreg_nx = '0;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                    if (MSB_FIRST) begin
                        shreg_nx = {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_nx = {1'b0, shreg[WIDTH-1:1]};
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                shreg_nx = '0;
            end
        endcase
    end

    // Output logic: ready is masked by reset so a word offered during reset
    // is never taken; sout is forced low outside bit cycles.
    always_comb begin
        din_ready     = 1'b0;
        sout_nx       = 1'b0;
        sout_valid_nx = 1'b0;
        sout_last_nx  = 1'b0;
        if (!rst) begin
            din_ready = (state == IDLE) || last_bit;
        end
        if (state == SHIFT) begin
            sout_valid_nx = 1'b1;
            sout_nx       = bit_now;
            sout_last_nx  = last_bit;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer, MSB-first and LSB-first instances

module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din_m, din_l;
    logic       dv_m, dv_l;
    logic       rdy_m, rdy_l;
    logic       so_m, sv_m, sl_m, bz_m;
    logic       so_l, sv_l, sl_l, bz_l;

    int errors;
    int checks;
    int cyc;
    bit mon_en;

    typedef struct {
        bit b;
        bit l;
        int c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
        .sout(so_m), .sout_valid(sv_m), .sout_last(sl_m), .busy(bz_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
        .sout(so_l), .sout_valid(sv_l), .sout_last(sl_l), .busy(bz_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input logic act, input logic req, input string nm);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, req);
        end
    endtask

    task automatic chk_int(input int act, input int req, input string nm);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
        end
    endtask

    // Monitor for one instance: if the scoreboard holds a bit due in this
    // cycle it must be on the wire, otherwise the outputs must be idle.
    task automatic mon(input int k, input logic s, input logic v, input logic l, input logic b);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (k == 0) begin
            if (q0.size() > 0 && q0[0].c == cyc) begin
                e = q0.pop_front();
                have = 1'b1;
            end
        end else begin
            if (q1.size() > 0 && q1[0].c == cyc) begin
                e = q1.pop_front();
                have = 1'b1;
            end
        end
        if (have) begin
            chk(v, 1'b1, k == 0 ? "msb.sout_valid" : "lsb.sout_valid");
            chk(s, e.b,  k == 0 ? "msb.sout"       : "lsb.sout");
            chk(l, e.l,  k == 0 ? "msb.sout_last"  : "lsb.sout_last");
            chk(b, 1'b1, k == 0 ? "msb.busy"       : "lsb.busy");
        end else begin
            chk(v, 1'b0, k == 0 ? "msb.idle_valid" : "lsb.idle_valid");
            chk(s, 1'b0, k == 0 ? "msb.idle_sout"  : "lsb.idle_sout");
            chk(l, 1'b0, k == 0 ? "msb.idle_last"  : "lsb.idle_last");
            chk(b, 1'b0, k == 0 ? "msb.idle_busy"  : "lsb.idle_busy");
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, so_m, sv_m, sl_m, bz_m);
            mon(1, so_l, sv_l, sl_l, bz_l);
        end
    end

    // Offer a word, wait for the handshake, then push its bits with the
    // cycles in which they are due (edges E+1..E+8).
    task automatic send(input int k, input logic [7:0] w, output int e);
        bit   ok;
        exp_t x;
        ok = 1'b0;
        if (k == 0) begin din_m = w; dv_m = 1'b1; end
        else        begin din_l = w; dv_l = 1'b1; end
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if ((k == 0 && rdy_m) || (k == 1 && rdy_l)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL handshake_timeout word %h inst %0d", w, k);
            e = -1;
        end else begin
            @(posedge clk);
            #1;
            e = cyc;
            for (int i = 0; i < 8; i++) begin
                x.b = (k == 0) ? w[7-i] : w[i];
                x.l = (i == 7);
                x.c = e + 1 + i;
                if (k == 0) q0.push_back(x);
                else        q1.push_back(x);
            end
        end
        if (k == 0) dv_m = 1'b0;
        else        dv_l = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int e1, e2;

    initial begin
        errors = 0;
        checks = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        din_m  = 8'h00; din_l = 8'h00;
        dv_m   = 1'b0;  dv_l  = 1'b0;

        // Reset state
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk(rdy_m, 1'b0, "reset.din_ready_msb");
        chk(rdy_l, 1'b0, "reset.din_ready_lsb");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(rdy_m, 1'b1, "post_reset.din_ready_msb");
        chk(rdy_l, 1'b1, "post_reset.din_ready_lsb");

        // Single word A5, MSB first: 1,0,1,0,0,1,0,1
        @(posedge clk); #1;
        send(0, 8'hA5, e1);
        idle_cycles(12);

        // Single word 01, LSB first: 1 then seven 0s
        send(1, 8'h01, e1);
        idle_cycles(12);

        // Back-to-back A5 then 3C, second accepted on last-bit edge
        send(0, 8'hA5, e1);
        send(0, 8'h3C, e2);
        chk_int(e2 - e1, 8, "b2b.handshake_gap");
        idle_cycles(20);

        // FF in flight, 00 offered meanwhile; 00 only taken on last-bit edge
        send(0, 8'hFF, e1);
        din_m = 8'h00;
        dv_m  = 1'b1;
        @(negedge clk);
        chk(rdy_m, 1'b0, "inflight.din_ready_low");
        @(posedge clk); #1;
        send(0, 8'h00, e2);
        chk_int(e2 - e1, 8, "inflight.accept_edge");
        idle_cycles(20);

        // Reset during bit 3 of A5 abandons the word
        send(0, 8'hA5, e1);
        while (cyc < e1 + 3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        while (q0.size() > 0 && q0[$].c >= cyc) void'(q0.pop_back());
        while (q1.size() > 0 && q1[$].c >= cyc) void'(q1.pop_back());
        rst = 1'b0;
        @(negedge clk);
        chk(rdy_m, 1'b1, "abandon.din_ready_after_release");
        @(posedge clk); #1;
        send(0, 8'h5A, e1);
        idle_cycles(12);

        // Reset held with valid offered: nothing accepted, outputs stay 0
        rst   = 1'b1;
        dv_m  = 1'b1; din_m = 8'hC3;
        dv_l  = 1'b1; din_l = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(rdy_m, 1'b0, "rst_hold.din_ready_msb");
            chk(rdy_l, 1'b0, "rst_hold.din_ready_lsb");
        end
        @(posedge clk); #1;
        dv_m = 1'b0; dv_l = 1'b0;
        rst  = 1'b0;
        idle_cycles(12);

        @(negedge clk);
        chk_int(q0.size(), 0, "end.queue_msb_empty");
        chk_int(q1.size(), 0, "end.queue_lsb_empty");
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means bit WIDTH-1 is sent first and 0 means bit 0 is sent first.
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port din  input  WIDTH  parallel word to transmit.
REQ-006 The block SHALL have port din_valid  input  1  din holds a word offered for transmission.
REQ-007 The block SHALL have port din_ready  output  1  block accepts din on this edge if din_valid is high.
REQ-008 The block SHALL have port sout  output  1  serial data bit.
REQ-009 The block SHALL have port sout_valid  output  1  sout carries a data bit this cycle.
REQ-010 The block SHALL have port sout_last  output  1  sout carries the final bit of a word.
REQ-011 The block SHALL have port busy  output  1  a word is being shifted out.

Function
REQ-012 The block SHALL implement states IDLE and SHIFT, with a bit counter cnt of ceil(log2(WIDTH)) bits and a WIDTH-bit shift register.
REQ-013 A handshake SHALL occur on a rising edge where din_valid=1 and din_ready=1; din SHALL be sampled only on a handshake.
REQ-014 din_ready SHALL be 1 when state=IDLE, or when state=SHIFT and cnt=WIDTH-1; otherwise 0; it SHALL be 0 whenever rst=1.
REQ-015 IDLE to SHIFT SHALL occur on a handshake, with cnt loaded to 0 and the shift register loaded with din.
REQ-016 In SHIFT, cnt SHALL increment each cycle; at cnt=WIDTH-1 the state SHALL become IDLE if there is no handshake, or remain SHIFT with cnt=0 and a new word loaded if there is one.
REQ-017 sout, sout_valid, sout_last and busy SHALL be registered outputs; a word accepted at edge N SHALL present its first bit from edge N+1, and its bits SHALL occupy exactly WIDTH consecutive cycles.
REQ-018 Bit order SHALL follow MSB_FIRST; a back-to-back word accepted on the last bit SHALL start on the immediately following cycle, with no gap cycle.
REQ-019 sout_valid and busy SHALL be 1 for every bit cycle; sout_last SHALL be 1 only in the final bit cycle of each word.
REQ-020 When sout_valid=0, sout SHALL be 0 and sout_last SHALL be 0.
REQ-021 Changes on din or din_valid while din_ready=0 SHALL have no effect on the word in flight.
REQ-022 There is no backpressure on the serial side; the consumer SHALL accept every bit for which sout_valid=1.

Reset
REQ-023 On a rising edge with rst=1, the block SHALL set state=IDLE, cnt=0, shift register=0, sout=0, sout_valid=0, sout_last=0 and busy=0.
REQ-024 rst SHALL take priority over a simultaneous handshake, and the offered word SHALL be dropped.
REQ-025 Reset during SHIFT SHALL abandon the word in flight, and no further bits of it SHALL appear.
REQ-026 The first edge after rst deasserts SHALL see din_ready=1.

Verification
REQ-027 WIDTH=8, MSB_FIRST=1, din=8'hA5 for one handshake -> sout = 1,0,1,0,0,1,0,1 over cycles N+1..N+8; sout_valid high for 8 cycles; sout_last only at N+8; then IDLE with sout_valid=0.
REQ-028 WIDTH=8, MSB_FIRST=0, din=8'h01 -> sout = 1 followed by seven 0s; sout_last on the eighth bit.
REQ-029 8'hA5 then 8'h3C with din_valid held continuously -> 16 contiguous sout_valid cycles; second handshake at the edge where cnt=7; sout_last pulses at bits 8 and 16.
REQ-030 din=8'hFF accepted, then din changed to 8'h00 with din_valid=1 during bits 2..7 -> transmitted word is eight 1s; 8'h00 is accepted only on the last-bit edge.
REQ-031 rst=1 asserted during bit 3 of 8'hA5 -> from the next edge, sout_valid=0, busy=0 and no further bits appear; after release, din_ready=1 and 8'h5A transmits correctly.
REQ-032 rst=1 held together with din_valid=1 -> din_ready=0, no word accepted, all outputs 0.
